rbz_reg_spi: RTL

Secondary SPI peripheral feeding the raycaster's rendering-parameter inputs: sky/floor colour, floor leak, "other" position, vertical shift, vinf and map-debug selectors. Receives frames on the register SPI pins (reg_sclk, reg_mosi, reg_ss_n, asynchronous to `clk`) and writes decoded payloads into a shadow bank. The shadow bank copies into the live bank on a frame-boundary strobe, so parameters never change mid-frame. Sits between the top-level `uio_in[4:2]` pins and `rbzero`'s parameter ports.

---
 rtl/rbz_reg_spi_pkg.sv | 69 ++++++
 rtl/rbz_reg_spi_if.sv | 9 +
 rtl/rbz_reg_spi_sync.sv | 46 ++++
 rtl/rbz_sync_edge.sv | 33 +++
 rtl/rbz_reg_spi.sv | 136 +++++++++++++
 5 files changed

// File: rtl/rbz_reg_spi_pkg.sv
// Shared constants, FSM encoding and parameter-bank payload for the register SPI peripheral.
package rbz_reg_pkg;

  localparam int unsigned FRAME_BITS = 20;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CMD_W      = 4;
  localparam int unsigned PAY_W      = 16;
  localparam int unsigned COL_W      = 6;
  localparam int unsigned WALL_W     = 2;

  localparam logic [CMD_W-1:0] CMD_SKY    = 4'd0;
  localparam logic [CMD_W-1:0] CMD_FLOOR  = 4'd1;
  localparam logic [CMD_W-1:0] CMD_LEAK   = 4'd2;
  localparam logic [CMD_W-1:0] CMD_OTHER  = 4'd3;
  localparam logic [CMD_W-1:0] CMD_VSHIFT = 4'd4;
  localparam logic [CMD_W-1:0] CMD_VINF   = 4'd5;
  localparam logic [CMD_W-1:0] CMD_MAPD   = 4'd6;

  localparam logic [COL_W-1:0] SKY_RST   = 6'h15;
  localparam logic [COL_W-1:0] FLOOR_RST = 6'h2A;

  typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_e;

  typedef struct packed {
    logic [COL_W-1:0]  sky;
    logic [COL_W-1:0]  floor;
    logic [COL_W-1:0]  leak;
    logic [COL_W-1:0]  otherx;
    logic [COL_W-1:0]  othery;
    logic [COL_W-1:0]  vshift;
    logic              vinf;
    logic [COL_W-1:0]  mapdx;
    logic [COL_W-1:0]  mapdy;
    logic [WALL_W-1:0] mapdxw;
    logic [WALL_W-1:0] mapdyw;
  } params_t;

  localparam params_t PARAMS_RST = '{
    sky: SKY_RST, floor: FLOOR_RST, leak: 6'h00, otherx: 6'h00, othery: 6'h00,
    vshift: 6'h00, vinf: 1'b0, mapdx: 6'h00, mapdy: 6'h00, mapdxw: 2'h0, mapdyw: 2'h0
  };

  // Decode one committed frame into the bank; unknown commands leave it untouched.
  function automatic params_t apply_cmd(params_t cur, logic [CMD_W-1:0] cmd,
                                        logic [PAY_W-1:0] p);
    params_t nxt;
    nxt = cur;
    case (cmd)
      CMD_SKY:    nxt.sky    = p[5:0];
      CMD_FLOOR:  nxt.floor  = p[5:0];
      CMD_LEAK:   nxt.leak   = p[5:0];
      CMD_OTHER: begin
        nxt.otherx = p[11:6];
        nxt.othery = p[5:0];
      end
      CMD_VSHIFT: nxt.vshift = p[5:0];
      CMD_VINF:   nxt.vinf   = p[0];
      CMD_MAPD: begin
        nxt.mapdx  = p[15:10];
        nxt.mapdy  = p[9:4];
        nxt.mapdxw = p[3:2];
        nxt.mapdyw = p[1:0];
      end
      default: ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rbz_reg_spi_if.sv
// Register SPI pin bundle: the host drives it, the peripheral samples it.
interface rbz_reg_spi_if;
  logic sclk;
  logic mosi;
  logic ss_n;

  modport master (output sclk, output mosi, output ss_n);
  modport slave  (input  sclk, input  mosi, input  ss_n);
endinterface

// File: rtl/rbz_reg_spi_sync.sv
// Brings the asynchronous SPI pins into the clk domain and exposes the events the FSM needs.
module rbz_reg_spi_sync (
  input  logic          clk,
  input  logic          reset,
  rbz_reg_spi_if.slave  spi,
  output logic          o_sclk_rise_c,
  output logic          o_ss_fall_c,
  output logic          o_ss_rise_c,
  output logic          o_mosi
);

  logic w_sclk_level_unused;
  logic w_sclk_fall_unused;
  logic w_ss_level_unused;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  rbz_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk      (clk),
    .reset    (reset),
    .i_d      (spi.sclk),
    .o_level  (w_sclk_level_unused),
    .o_rise_c (o_sclk_rise_c),
    .o_fall_c (w_sclk_fall_unused)
  );

  // Select idles high so a pin already low at reset release reads as a fresh falling edge.
  rbz_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk      (clk),
    .reset    (reset),
    .i_d      (spi.ss_n),
    .o_level  (w_ss_level_unused),
    .o_rise_c (o_ss_rise_c),
    .o_fall_c (o_ss_fall_c)
  );

  rbz_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk      (clk),
    .reset    (reset),
    .i_d      (spi.mosi),
    .o_level  (o_mosi),
    .o_rise_c (w_mosi_rise_unused),
    .o_fall_c (w_mosi_fall_unused)
  );

endmodule

// File: rtl/rbz_sync_edge.sv
// Two-flop synchronizer plus a delay flop giving single-cycle rise/fall pulses.
module rbz_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_s1;
  logic r_s2;
  logic r_dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= RST_VAL;
      r_s2  <= RST_VAL;
      r_dly <= RST_VAL;
    end else begin
      r_s1  <= i_d;
      r_s2  <= r_s1;
      r_dly <= r_s2;
    end
  end

  assign o_level  = r_s2;
  assign o_rise_c = r_s2 & ~r_dly;
  assign o_fall_c = ~r_s2 & r_dly;

endmodule

// File: rtl/rbz_reg_spi.sv
// Register SPI receiver: frames decode into a shadow bank that moves to the live bank on i_load.
module rbz_reg_spi
  import rbz_reg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_reg_sclk,
  input  logic             i_reg_mosi,
  input  logic             i_reg_ss_n,
  input  logic             i_load,
  output logic [COL_W-1:0] o_sky,
  output logic [COL_W-1:0] o_floor,
  output logic [COL_W-1:0] o_leak,
  output logic [COL_W-1:0] o_otherx,
  output logic [COL_W-1:0] o_othery,
  output logic [COL_W-1:0] o_vshift,
  output logic             o_vinf,
  output logic [COL_W-1:0] o_mapdx,
  output logic [COL_W-1:0] o_mapdy,
  output logic [WALL_W-1:0] o_mapdxw,
  output logic [WALL_W-1:0] o_mapdyw,
  output logic             o_frame_err
);

  rbz_reg_spi_if w_spi ();
  assign w_spi.sclk = i_reg_sclk;
  assign w_spi.mosi = i_reg_mosi;
  assign w_spi.ss_n = i_reg_ss_n;

  logic w_sclk_rise;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_mosi;

  rbz_reg_spi_sync u_sync (
    .clk           (clk),
    .reset         (reset),
    .spi           (w_spi),
    .o_sclk_rise_c (w_sclk_rise),
    .o_ss_fall_c   (w_ss_fall),
    .o_ss_rise_c   (w_ss_rise),
    .o_mosi        (w_mosi)
  );

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_bitcnt;
  logic [FRAME_BITS-1:0] r_shift;
  params_t               r_shadow;
  params_t               r_live;
  logic                  r_frame_err;

  logic w_full;
  logic w_clear;
  logic w_shift;
  logic w_commit;
  logic w_err;

  assign w_full = (r_bitcnt == CNT_W'(FRAME_BITS));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_ss_rise)                 w_state_nxt = IDLE;
        else if (w_sclk_rise && w_full) w_state_nxt = OVERRUN;
      end
      OVERRUN: if (w_ss_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_clear  = 1'b0;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE:    w_clear = w_ss_fall;
      SHIFT: begin
        if (w_ss_rise) begin
          w_commit = w_full;
          w_err    = ~w_full;
        end else if (w_sclk_rise && !w_full) begin
          w_shift = 1'b1;
        end
      end
      OVERRUN: w_err = w_ss_rise;
      default: ;
    endcase
  end

  // Load samples the shadow before this cycle's commit lands, so a coinciding frame waits a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_shadow    <= PARAMS_RST;
      r_live      <= PARAMS_RST;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_clear) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
      end else if (w_shift) begin
        r_bitcnt <= r_bitcnt + CNT_W'(1);
        r_shift  <= {r_shift[FRAME_BITS-2:0], w_mosi};
      end
      if (w_commit)
        r_shadow <= apply_cmd(r_shadow, r_shift[FRAME_BITS-1 -: CMD_W], r_shift[PAY_W-1:0]);
      if (i_load)
        r_live <= r_shadow;
    end
  end

  assign o_sky       = r_live.sky;
  assign o_floor     = r_live.floor;
  assign o_leak      = r_live.leak;
  assign o_otherx    = r_live.otherx;
  assign o_othery    = r_live.othery;
  assign o_vshift    = r_live.vshift;
  assign o_vinf      = r_live.vinf;
  assign o_mapdx     = r_live.mapdx;
  assign o_mapdy     = r_live.mapdy;
  assign o_mapdxw    = r_live.mapdxw;
  assign o_mapdyw    = r_live.mapdyw;
  assign o_frame_err = r_frame_err;

endmodule
